// File: rtl/light_mode_fsm_pkg.sv
// Shared lamp mode encodings and mode sequencing for the light-stand design.
package light_mode_fsm_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_LOW  = 2'd1,
    MODE_MID  = 2'd2,
    MODE_HIGH = 2'd3
  } mode_e;

  // Press order OFF -> LOW -> MID -> HIGH -> OFF, the 2-bit wrap closes the loop.
  function automatic mode_e next_mode(input mode_e m);
    return mode_e'(m + 2'd1);
  endfunction

endpackage

// File: rtl/light_mode_fsm_pwm_generator.sv
// Free-running PWM: period counter, duty latched at period wrap, registered lamp drive.
module light_mode_fsm_pwm_generator #(
  parameter int PWM_PERIOD = 100,
  parameter int DUTY_W     = $clog2(PWM_PERIOD + 1)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [DUTY_W-1:0] duty,
  input  logic              force_zero,
  output logic              o_led
);

  localparam int CNT_W = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PWM_PERIOD - 1);

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic [DUTY_W-1:0] duty_q;
  logic [DUTY_W-1:0] duty_next;
  logic              wrap;

  assign wrap     = (cnt == CNT_LAST);
  assign cnt_next = wrap ? '0 : cnt + CNT_W'(1);

  // Duty only changes at a period boundary, except that turning off is immediate.
  assign duty_next = force_zero ? '0 : (wrap ? duty : duty_q);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt    <= '0;
      duty_q <= '0;
      o_led  <= 1'b0;
    end else begin
      cnt    <= cnt_next;
      duty_q <= duty_next;
      o_led  <= (DUTY_W'(cnt_next) < duty_next);
    end
  end

endmodule

// File: rtl/light_mode_fsm.sv
// Lamp mode FSM driven by debounced press pulses, with PWM lamp output.
// Optional inactivity auto-off is enabled by defining LIGHT_AUTO_OFF_EN.
module light_mode_fsm
  import light_mode_fsm_pkg::*;
#(
  parameter int          PWM_PERIOD      = 100,
  parameter int          DUTY_LOW        = 25,
  parameter int          DUTY_MID        = 50,
  parameter int          DUTY_HIGH       = 100,
  parameter int unsigned AUTO_OFF_CYCLES = 500_000_000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_button,
  output logic       o_led,
  output logic [1:0] o_state,
  output logic       o_mode_change
);

  localparam int DUTY_W = $clog2(PWM_PERIOD + 1);

  function automatic logic [DUTY_W-1:0] sat_duty(input int d);
    if (d >= PWM_PERIOD) return DUTY_W'(PWM_PERIOD);
    else if (d <= 0)     return '0;
    else                 return DUTY_W'(d);
  endfunction

  mode_e             state;
  logic              force_off;
  logic              enter_off;
  logic [DUTY_W-1:0] duty_sel;

  always_comb begin
    duty_sel = '0;
    case (state)
      MODE_LOW:  duty_sel = sat_duty(DUTY_LOW);
      MODE_MID:  duty_sel = sat_duty(DUTY_MID);
      MODE_HIGH: duty_sel = sat_duty(DUTY_HIGH);
      default:   duty_sel = '0;
    endcase
  end

  // A press always wins over the inactivity timeout on the same cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state         <= MODE_OFF;
      o_mode_change <= 1'b0;
    end else begin
      o_mode_change <= 1'b0;
      if (i_button) begin
        state         <= next_mode(state);
        o_mode_change <= 1'b1;
      end else if (force_off) begin
        state         <= MODE_OFF;
        o_mode_change <= 1'b1;
      end
    end
  end

  assign o_state   = state;
  assign enter_off = (i_button && state == MODE_HIGH) || force_off;

`ifdef LIGHT_AUTO_OFF_EN
  localparam logic [31:0] IDLE_LAST = 32'(AUTO_OFF_CYCLES - 1);

  logic [31:0] idle_cnt;

  assign force_off = !i_button && (state != MODE_OFF) && (idle_cnt == IDLE_LAST);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      idle_cnt <= '0;
    end else if (i_button || state == MODE_OFF || force_off) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 32'd1;
    end
  end
`else
  logic unused_auto_off;

  assign unused_auto_off = ^AUTO_OFF_CYCLES;
  assign force_off       = 1'b0;
`endif

  light_mode_fsm_pwm_generator #(
    .PWM_PERIOD (PWM_PERIOD),
    .DUTY_W     (DUTY_W)
  ) u_pwm (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .duty       (duty_sel),
    .force_zero (enter_off),
    .o_led      (o_led)
  );

endmodule

// File: tb/tb_light_mode_fsm.sv
// Directed and random stimulus for light_mode_fsm against a cycle-count reference model.
module tb_light_mode_fsm;

  localparam int P  = 4;
  localparam int DL = 1;
  localparam int DM = 2;
  localparam int DH = 4;
  localparam int AO = 20;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_button = 1'b0;
  logic       o_led;
  logic [1:0] o_state;
  logic       o_mode_change;

  int tests = 0;
  int fails = 0;

  // Reference model: mode, edges since reset release, duty applied to the current period.
  int m_mode;
  int m_k;
  int m_applied;
  int m_last_act;
  bit m_led;
  bit m_strobe;

  light_mode_fsm #(
    .PWM_PERIOD      (P),
    .DUTY_LOW        (DL),
    .DUTY_MID        (DM),
    .DUTY_HIGH       (DH),
    .AUTO_OFF_CYCLES (AO)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_button      (i_button),
    .o_led         (o_led),
    .o_state       (o_state),
    .o_mode_change (o_mode_change)
  );

  always #5 i_clk = ~i_clk;

  function automatic int duty_of(input int mode);
    int d;
    case (mode)
      1:       d = DL;
      2:       d = DM;
      3:       d = DH;
      default: d = 0;
    endcase
    return (d > P) ? P : d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":state"},  32'(o_state),       32'(m_mode));
    chk({tag, ":strobe"}, 32'(o_mode_change), 32'(m_strobe));
    chk({tag, ":led"},    32'(o_led),         32'(m_led));
  endtask

  task automatic model_reset();
    m_mode     = 0;
    m_k        = 0;
    m_applied  = 0;
    m_last_act = 0;
    m_led      = 1'b0;
    m_strobe   = 1'b0;
  endtask

  // Counter after edge k is k mod P; a new period picks up the duty of the mode held before it.
  task automatic model_edge(input bit b);
    int prev;
    bit forced;
    prev   = m_mode;
    forced = 1'b0;
    m_k++;
`ifdef LIGHT_AUTO_OFF_EN
    forced = !b && (prev != 0) && (m_k - m_last_act == AO);
`endif
    if (b)           m_mode = (prev + 1) % 4;
    else if (forced) m_mode = 0;
    m_strobe = b || forced;
    if (m_k % P == 0) m_applied = duty_of(prev);
    if (m_mode == 0 && prev != 0) m_applied = 0;
    m_led = ((m_k % P) < m_applied);
    if (b || prev == 0 || forced) m_last_act = m_k;
  endtask

  task automatic step(input bit b, input string tag);
    i_button = b;
    @(posedge i_clk);
    model_edge(b);
    #1;
    check_all(tag);
    @(negedge i_clk);
    i_button = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    i_reset  = 1'b1;
    i_button = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    repeat (cycles) @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  // Idle until the next sampled edge lands on the given counter phase.
  task automatic align_phase(input int ph);
    for (int i = 0; i < P && ((m_k + 1) % P) != ph; i++) step(1'b0, "align");
  endtask

  initial begin
    #2;
    do_reset(5);
    repeat (16) step(1'b0, "idle");

    for (int i = 0; i < 4; i++) begin
      step(1'b1, "press");
      repeat (11) step(1'b0, "steady");
    end

    step(1'b1, "to_low");
    step(1'b1, "to_mid");
    repeat (8) step(1'b0, "mid_hold");
    align_phase(0);
    step(1'b1, "wrap_press");
    repeat (12) step(1'b0, "high_hold");

    align_phase(2);
    step(1'b1, "off_mid");
    repeat (8) step(1'b0, "off_hold");

    repeat (3) step(1'b1, "burst");
    repeat (8) step(1'b0, "burst_hold");
    step(1'b1, "burst_off");
    repeat (4) step(1'b0, "off_hold2");

    step(1'b1, "to_low2");
`ifdef LIGHT_AUTO_OFF_EN
    repeat (25) step(1'b0, "timeout");
    step(1'b1, "to_low3");
    repeat (19) step(1'b0, "pre_timeout");
    step(1'b1, "timeout_press");
    repeat (24) step(1'b0, "mid_timeout");
`else
    repeat (100) step(1'b0, "low_hold");
`endif

    repeat (300) step(($urandom_range(0, 3) == 0), "rand");

    step(1'b1, "pre_reset");
    step(1'b0, "pre_reset");
    do_reset(2);
    repeat (12) step(1'b0, "post_reset");
    step(1'b1, "post_reset_press");
    repeat (8) step(1'b0, "post_reset_hold");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
